// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: log2 helper, read-mode constants and parameter legality check.
package fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Legal set: DEPTH a power of two >= 2, AF in 1..DEPTH, AE in 0..DEPTH-1, FWFT 0/1.
    function automatic bit params_ok(input int unsigned depth,
                                     input int unsigned af,
                                     input int unsigned ae,
                                     input int unsigned fwft);
        return (depth >= 2) && ((depth & (depth - 1)) == 0)
            && (af >= 1) && (af <= depth)
            && (ae <= depth - 1)
            && (fwft <= FWFT_ON);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// FIFO control/data/status bundle.
// master: drives flush, clr_err, wr_en, wr_data, rd_en; observes data and status.
// slave : the FIFO; drives rd_data, rd_valid, full/empty/almost flags, count, error flags.
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned D_WIDTH = 8
);
    localparam int unsigned CNT_W = clog2(DEPTH) + 1;

    logic               flush;
    logic               clr_err;
    logic               wr_en;
    logic [D_WIDTH-1:0] wr_data;
    logic               rd_en;
    logic [D_WIDTH-1:0] rd_data;
    logic               rd_valid;
    logic               full_o;
    logic               empty_o;
    logic               almost_full_o;
    logic               almost_empty_o;
    logic [CNT_W-1:0]   count_o;
    logic               overflow_o;
    logic               underflow_o;

    modport master (
        output flush, clr_err, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush, clr_err, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with synchronous write and asynchronous read.
// Ports: clk, we_i/waddr_i/wdata_i (write port), raddr_i -> rdata_c_o (combinational read).
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [clog2(DEPTH)-1:0]  waddr_i,
    input  logic [D_WIDTH-1:0]       wdata_i,
    input  logic [clog2(DEPTH)-1:0]  raddr_i,
    output logic [D_WIDTH-1:0]       rdata_c_o
);

    logic [D_WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT read.
// Ports: clk, reset (async active-low), bus (sync_fifo_flags_if.slave).
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1,
    parameter int unsigned FWFT      = FWFT_OFF
) (
    input  logic            clk,
    input  logic            reset,
    sync_fifo_flags_if.slave bus
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_err
        $error("sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH/FWFT");
    end

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d, empty_q, empty_d;
    logic               af_q, af_d, ae_q, ae_d;
    logic               ovf_q, ovf_d, udf_q, udf_d;
    logic               wr_acc_c, rd_acc_c, mem_we_c;
    logic [D_WIDTH-1:0] mem_rdata_c;

    // Acceptance, pointer/count update and flag next-state.
    always_comb begin
        wr_acc_c = bus.wr_en & ~full_q;
        rd_acc_c = bus.rd_en & ~empty_q;
        mem_we_c = wr_acc_c & ~bus.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_acc_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error in the same cycle as clr_err wins.
        ovf_d = (ovf_q & ~bus.clr_err) | (bus.wr_en & full_q & ~bus.flush);
        udf_d = (udf_q & ~bus.clr_err) | (bus.rd_en & empty_q & ~bus.flush);

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_THRESH));
        ae_d    = (count_d <= CNT_W'(AE_THRESH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH   (DEPTH),
        .D_WIDTH (D_WIDTH)
    ) u_mem (
        .clk       (clk),
        .we_i      (mem_we_c),
        .waddr_i   (wr_ptr_q),
        .wdata_i   (bus.wr_data),
        .raddr_i   (rd_ptr_q),
        .rdata_c_o (mem_rdata_c)
    );

    if (FWFT == FWFT_OFF) begin : g_reg_read
        logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
        logic               rd_valid_q, rd_valid_d;

        // Registered read: data captured on accept, valid pulses one cycle.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc_c & ~bus.flush;
            if (rd_valid_d) rd_data_d = mem_rdata_c;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        // Head word is presented directly; rd_en pops it.
        assign bus.rd_data  = mem_rdata_c;
        assign bus.rd_valid = ~empty_q;
    end

    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = af_q;
    assign bus.almost_empty_o = ae_q;
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = udf_q;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, fully parametrised FIFO for intra-domain buffering, where the dual-clock FIFO's synchronisers are unnecessary.
- Depth and pointer widths are generalised: no hard-coded pointer width.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DEPTH, 8, number of entries; power of 2, >= 2.
- D_WIDTH, 8, data width in bits.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- flush, input, 1, synchronous clear of FIFO contents.
- clr_err, input, 1, synchronous clear of the sticky error flags.
- wr_en, input, 1, write request.
- wr_data, input, D_WIDTH, write data.
- rd_en, input, 1, read request.
- rd_data, output, D_WIDTH, read data.
- rd_valid, output, 1, rd_data is valid.
- full_o, output, 1, count == DEPTH.
- empty_o, output, 1, count == 0.
- almost_full_o, output, 1, count >= AF_THRESH.
- almost_empty_o, output, 1, count <= AE_THRESH.
- count_o, output, clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- overflow_o, output, 1, sticky: a write was rejected.
- underflow_o, output, 1, sticky: a read was rejected.

Behaviour:
- Widths: ADDR_W = clog2(DEPTH). wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count is ADDR_W+1 bits.
- Acceptance:
  - A write is accepted iff wr_en & ~full_o.
  - A read is accepted iff rd_en & ~empty_o.
  - Both are evaluated on the pre-edge state.
- Pointer and count updates:
  - An accepted write stores wr_data at mem[wr_ptr] and increments wr_ptr.
  - An accepted read increments rd_ptr.
  - count: +1 for write only, -1 for read only, unchanged when both or neither are accepted.
- Simultaneous requests when full: the read is accepted, the write is rejected and overflow_o is set. The write is not admitted even though a slot frees that cycle.
- Simultaneous requests when empty: the write is accepted, the read is rejected and underflow_o is set.
- Any rejected request (wr_en while full, rd_en while empty) sets its sticky flag at the next edge. Flags hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the flag stays set.
- flush has priority over wr_en and rd_en that cycle: pointers, count and rd_valid go to 0. Memory contents are untouched and no error flags are set.
- Status outputs: full_o, empty_o, almost_full_o, almost_empty_o and count_o are decoded from registered count, so they change one edge after the causing request.
- FWFT = 0:
  - rd_data is a register loaded with mem[rd_ptr] on an accepted read, giving 1-cycle latency.
  - rd_valid pulses high for exactly the cycle after each accepted read.
  - rd_data holds its value otherwise.
- FWFT = 1:
  - rd_data = mem[rd_ptr] (asynchronous memory read).
  - rd_valid = ~empty_o.
  - rd_en acknowledges the current word and the next word appears after the edge.
  - A word written into an empty FIFO appears on rd_data one cycle after the write edge.
  - rd_data is don't-care while empty.
- Reset (asynchronous assert, any time, including mid-transfer):
  - wr_ptr = rd_ptr = 0, count_o = 0.
  - empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0.
  - overflow_o = underflow_o = 0, rd_valid = 0, rd_data = 0 (FWFT = 0 only).
  - Memory is not reset.
  - After reset release, the first edge operates normally.

Decomposition:
- Shared header/package fifo_pkg:
  - clog2 function.
  - Read-mode constants FWFT_OFF = 0, FWFT_ON = 1.
  - Parameter-legality checks (DEPTH power of 2, threshold ranges) as elaboration-time assertions.
- One sub-module: sync_fifo_mem.
  - Single-clock register array: synchronous write, asynchronous read port.
  - Parametrised by DEPTH and D_WIDTH.
- The top level holds pointers, count, flags and the rd_data register.

Test Plan (DEPTH=8, D_WIDTH=8, AF_THRESH=6, AE_THRESH=1 unless noted):
- Fill then drain: write 0x10..0x17 on consecutive cycles, then 8 reads.
  - almost_full_o rises after the 6th write; full_o = 1 and count_o = 8 after the 8th.
  - FWFT=0: rd_data = 0x10..0x17 in order, each with a 1-cycle rd_valid pulse.
  - Final state: empty_o = 1, count_o = 0, no error flags.
- Wrap-around: 5 writes, 5 reads, then 6 writes, 6 reads.
  - Data order is preserved across the pointer wrap; count_o peaks at 6; almost_full_o asserts at 6.
- Simultaneous requests:
  - When full, assert wr_en+rd_en: count_o goes to 7, overflow_o = 1, the rejected word never appears.
  - When empty, assert both: count_o goes to 1, underflow_o = 1.
  - Pulse clr_err: both flags return to 0.
- Flush: with 4 words held, assert flush together with wr_en and rd_en.
  - Next cycle: count_o = 0, empty_o = 1, rd_valid = 0, no flags set.
  - A subsequent write of 0xA5 then a read returns 0xA5.
- FWFT=1: write 0x3C into an empty FIFO.
  - One cycle after the write edge: rd_valid = 1 and rd_data = 0x3C with no rd_en.
  - Assert rd_en for one cycle: rd_valid drops and empty_o = 1.
- Async reset mid-operation: drop reset between clock edges while count_o = 5 and overflow_o = 1.
  - All outputs take reset values immediately, without waiting for a clock edge.
  - After release, write 0x01 then read returns 0x01.
